// File: rtl/operand_bypass_unit.sv
// operand_bypass_unit: EX-stage operand bypass network with its own in-flight
// writeback tracking. It picks each ALU source operand from the register file
// or from the youngest matching in-flight result. It also raises stall on a
// load-use hazard until the load data arrives.
//
// Ports:
//   clk, rst_n         clock (rising edge) and asynchronous active-low reset
//   flush              invalidate all tracked entries on the next edge
//   adv                pipeline advance; EX retires into entry 0 when not stalled
//   ex_valid/ex_we/ex_is_load/ex_rd/ex_result   EX instruction description
//   mem_load_valid/mem_load_data                data for the oldest pending load
//   src_addr/src_rf_data                        per-source address and RF read data
//   operand_out/fwd_sel/stall                   combinational bypass results
//   fwd_count          saturating count of retired forwarding instructions
module operand_bypass_unit #(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned NUM_SRC      = 2,
    parameter int unsigned BYPASS_DEPTH = 2,
    parameter int unsigned REG_AW       = 5,
    localparam int unsigned SELW        = $clog2(BYPASS_DEPTH + 1)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    input  logic                      adv,
    input  logic                      ex_valid,
    input  logic                      ex_we,
    input  logic                      ex_is_load,
    input  logic [REG_AW-1:0]         ex_rd,
    input  logic [XLEN-1:0]           ex_result,
    input  logic                      mem_load_valid,
    input  logic [XLEN-1:0]           mem_load_data,
    input  logic [NUM_SRC*REG_AW-1:0] src_addr,
    input  logic [NUM_SRC*XLEN-1:0]   src_rf_data,
    output logic [NUM_SRC*XLEN-1:0]   operand_out,
    output logic [NUM_SRC*SELW-1:0]   fwd_sel,
    output logic                      stall,
    output logic [15:0]               fwd_count
);

    logic              ent_valid [BYPASS_DEPTH];
    logic [REG_AW-1:0] ent_rd    [BYPASS_DEPTH];
    logic              ent_pend  [BYPASS_DEPTH];
    logic [XLEN-1:0]   ent_data  [BYPASS_DEPTH];

    logic              nxt_valid [BYPASS_DEPTH];
    logic [REG_AW-1:0] nxt_rd    [BYPASS_DEPTH];
    logic              nxt_pend  [BYPASS_DEPTH];
    logic [XLEN-1:0]   nxt_data  [BYPASS_DEPTH];

    logic              pend_any;
    logic [SELW-1:0]   pend_idx;
    logic              fill;
    logic              stall_any;
    logic              shift;
    logic              fwd_any;

    logic [REG_AW-1:0] src;
    logic              hit;
    logic              hit_pend;
    logic [SELW-1:0]   hit_idx;
    logic [XLEN-1:0]   hit_data;

    // Oldest valid pending entry (highest index) is the one the next load fills.
    always_comb begin
        pend_any = 1'b0;
        pend_idx = '0;
        for (int k = 0; k < int'(BYPASS_DEPTH); k++) begin
            if (ent_valid[k] && ent_pend[k]) begin
                pend_any = 1'b1;
                pend_idx = SELW'(k);
            end
        end
    end

    assign fill = mem_load_valid & pend_any;

    // Per-source match; descending scan so the youngest (lowest index) wins.
    always_comb begin
        operand_out = src_rf_data;
        fwd_sel     = '0;
        stall_any   = 1'b0;
        src         = '0;
        hit         = 1'b0;
        hit_pend    = 1'b0;
        hit_idx     = '0;
        hit_data    = '0;
        for (int i = 0; i < int'(NUM_SRC); i++) begin
            src      = src_addr[i*REG_AW +: REG_AW];
            hit      = 1'b0;
            hit_pend = 1'b0;
            hit_idx  = '0;
            hit_data = '0;
            for (int k = int'(BYPASS_DEPTH) - 1; k >= 0; k--) begin
                if (ent_valid[k] && (ent_rd[k] == src) && (src != '0)) begin
                    hit      = 1'b1;
                    hit_pend = ent_pend[k];
                    hit_idx  = SELW'(k);
                    hit_data = ent_data[k];
                end
            end
            if (hit) begin
                fwd_sel[i*SELW +: SELW] = hit_idx + SELW'(1);
                if (!hit_pend) begin
                    operand_out[i*XLEN +: XLEN] = hit_data;
                end else if (fill && (hit_idx == pend_idx)) begin
                    // Load data arriving this cycle is forwarded straight through.
                    operand_out[i*XLEN +: XLEN] = mem_load_data;
                end else begin
                    stall_any = 1'b1;
                end
            end
        end
    end

    assign stall   = ex_valid & stall_any;
    assign shift   = adv & ~stall;
    assign fwd_any = |fwd_sel;

    // Entry next-state: shift, then load fill at the entry's new position, then flush.
    always_comb begin
        for (int k = 0; k < int'(BYPASS_DEPTH); k++) begin
            nxt_valid[k] = ent_valid[k];
            nxt_rd[k]    = ent_rd[k];
            nxt_pend[k]  = ent_pend[k];
            nxt_data[k]  = ent_data[k];
        end
        if (shift) begin
            nxt_valid[0] = ex_valid & ex_we & (ex_rd != '0);
            nxt_rd[0]    = ex_rd;
            nxt_pend[0]  = ex_is_load;
            nxt_data[0]  = ex_result;
            for (int k = 1; k < int'(BYPASS_DEPTH); k++) begin
                nxt_valid[k] = ent_valid[k-1];
                nxt_rd[k]    = ent_rd[k-1];
                nxt_pend[k]  = ent_pend[k-1];
                nxt_data[k]  = ent_data[k-1];
            end
        end
        if (fill) begin
            for (int k = 0; k < int'(BYPASS_DEPTH); k++) begin
                if ((!shift && (SELW'(k) == pend_idx)) ||
                    (shift && (k > 0) && (SELW'(k - 1) == pend_idx))) begin
                    nxt_data[k] = mem_load_data;
                    nxt_pend[k] = 1'b0;
                end
            end
        end
        if (flush) begin
            for (int k = 0; k < int'(BYPASS_DEPTH); k++) begin
                nxt_valid[k] = 1'b0;
                nxt_pend[k]  = 1'b0;
            end
        end
    end

    // Entry state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < int'(BYPASS_DEPTH); k++) begin
                ent_valid[k] <= 1'b0;
                ent_rd[k]    <= '0;
                ent_pend[k]  <= 1'b0;
                ent_data[k]  <= '0;
            end
        end else begin
            for (int k = 0; k < int'(BYPASS_DEPTH); k++) begin
                ent_valid[k] <= nxt_valid[k];
                ent_rd[k]    <= nxt_rd[k];
                ent_pend[k]  <= nxt_pend[k];
                ent_data[k]  <= nxt_data[k];
            end
        end
    end

    // Saturating count of retiring instructions that used a bypass.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_count <= '0;
        end else if (shift && ex_valid && fwd_any && (fwd_count != 16'hFFFF)) begin
            fwd_count <= fwd_count + 16'd1;
        end
    end

endmodule
